// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts one byte per frame over valid/ready and shifts it out
// as start bit, 8 data bits LSB first, optional parity bit and 1 or 2 stop bits.
module uart_tx_serializer #(
  parameter int DIVISOR    = 868,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             stop_q, stop_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_c;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_MAX);

  // tx_d is the line level for the cycle after this edge, so tx stays registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_c  = 1'b0;
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (data_valid) begin
          state_d = START;
          shift_d = data_in;
          par_d   = (^data_in) ^ 1'(PARITY_ODD);
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            stop_d = 1'b0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            done_c  = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Gated with rst_n so a reset arriving on the final stop clock suppresses done.
  assign data_ready = (state_q == IDLE) && rst_n;
  assign done       = done_c && rst_n;
  assign tx         = tx_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four DIVISOR=4 instances covering the parity and
// stop-bit variants; expected line bits are queued at accept and checked per clock.
module tb_uart_tx_serializer;

  localparam int DIV = 4;
  localparam logic [3:0] PEN_V = 4'b0110;
  localparam logic [3:0] ODD_V = 4'b0100;
  localparam logic [3:0] TWO_V = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din [4];
  logic       dv [4];
  logic       rdy [4];
  logic       tx_w [4];
  logic       busy_w [4];
  logic       done_w [4];

  int pass_cnt = 0;
  int total_cnt = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      uart_tx_serializer #(
        .DIVISOR   (DIV),
        .PARITY_EN (int'(PEN_V[gi])),
        .PARITY_ODD(int'(ODD_V[gi])),
        .STOP_BITS (1 + int'(TWO_V[gi]))
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (din[gi]),
        .data_valid(dv[gi]),
        .data_ready(rdy[gi]),
        .tx        (tx_w[gi]),
        .busy      (busy_w[gi]),
        .done      (done_w[gi])
      );
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (rdy[k] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total_cnt++;
    if (rdy[k] !== 1'b1) $display("FAIL ready_wait inst%0d: data_ready=%b required 1", k, rdy[k]);
    else pass_cnt++;
  endtask

  task automatic push_frame(input int k, input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    if (PEN_V[k]) exp_q.push_back((^b) ^ ODD_V[k]);
    exp_q.push_back(1'b1);
    if (TWO_V[k]) exp_q.push_back(1'b1);
  endtask

  task automatic send(input int k, input logic [7:0] b, input bit hold, input bit clobber);
    wait_ready(k);
    din[k] = b;
    dv[k]  = 1'b1;
    push_frame(k, b);
    tick();
    if (clobber) din[k] = 8'h00;
    if (!hold) dv[k] = 1'b0;
  endtask

  task automatic check_frame(input int k, input string name);
    int  nb;
    int  errs;
    bit  e;
    bit  last;
    nb   = exp_q.size();
    errs = total_cnt - pass_cnt;
    for (int i = 0; i < nb; i++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < DIV; c++) begin
        last = (i == nb - 1) && (c == DIV - 1);
        total_cnt++;
        if (tx_w[k] !== e) $display("FAIL %s_tx inst%0d bit%0d clk%0d: tx=%b required %b", name, k, i, c, tx_w[k], e);
        else pass_cnt++;
        total_cnt++;
        if (busy_w[k] !== 1'b1) $display("FAIL %s_busy inst%0d bit%0d: busy=%b required 1", name, k, i, busy_w[k]);
        else pass_cnt++;
        total_cnt++;
        if (rdy[k] !== 1'b0) $display("FAIL %s_ready inst%0d bit%0d: data_ready=%b required 0", name, k, i, rdy[k]);
        else pass_cnt++;
        total_cnt++;
        if (done_w[k] !== last) $display("FAIL %s_done inst%0d bit%0d clk%0d: done=%b required %b", name, k, i, c, done_w[k], last);
        else pass_cnt++;
        tick();
      end
    end
    total_cnt++;
    if (busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 || tx_w[k] !== 1'b1 || rdy[k] !== 1'b1)
      $display("FAIL %s_after inst%0d: busy=%b done=%b tx=%b ready=%b required 0 0 1 1",
               name, k, busy_w[k], done_w[k], tx_w[k], rdy[k]);
    else pass_cnt++;
    $display("frame %s inst%0d: %0d bits, %0d clocks, errors %0d", name, k, nb, nb * DIV,
             (total_cnt - pass_cnt) - errs);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      din[k] = 8'h00;
      dv[k]  = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 || rdy[k] !== 1'b0)
        $display("FAIL reset_hold inst%0d: tx=%b busy=%b done=%b ready=%b required 1 0 0 0",
                 k, tx_w[k], busy_w[k], done_w[k], rdy[k]);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (rdy[k] !== 1'b1) $display("FAIL reset_release inst%0d: data_ready=%b required 1", k, rdy[k]);
      else pass_cnt++;
    end
    $display("reset: done");
  endtask

  task automatic test_basic();
    send(0, 8'h55, 1'b0, 1'b0);
    check_frame(0, "basic55");
    send(0, 8'hE4, 1'b0, 1'b0);
    check_frame(0, "basicE4");
  endtask

  task automatic test_parity();
    send(1, 8'hA3, 1'b0, 1'b0);
    check_frame(1, "par_even");
    send(2, 8'hA3, 1'b0, 1'b0);
    check_frame(2, "par_odd");
    send(2, 8'h07, 1'b0, 1'b0);
    check_frame(2, "par_odd07");
  endtask

  task automatic test_two_stop();
    send(3, 8'hFF, 1'b0, 1'b0);
    check_frame(3, "stop2");
  endtask

  task automatic test_back_to_back();
    send(0, 8'h01, 1'b1, 1'b0);
    check_frame(0, "b2b_01");
    send(0, 8'h80, 1'b0, 1'b0);
    check_frame(0, "b2b_80");
  endtask

  task automatic test_data_change();
    send(0, 8'hC3, 1'b0, 1'b1);
    check_frame(0, "chgC3");
  endtask

  task automatic test_reset_mid_frame();
    wait_ready(0);
    din[0] = 8'hC3;
    dv[0]  = 1'b1;
    tick();
    dv[0]  = 1'b0;
    repeat (21) tick();
    total_cnt++;
    if (tx_w[0] !== 1'b0) $display("FAIL midrst_bit4 inst0: tx=%b required 0", tx_w[0]);
    else pass_cnt++;
    rst_n = 1'b0;
    tick();
    total_cnt++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || rdy[0] !== 1'b0)
      $display("FAIL midrst_abort inst0: tx=%b busy=%b done=%b ready=%b required 1 0 0 0",
               tx_w[0], busy_w[0], done_w[0], rdy[0]);
    else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (rdy[0] !== 1'b1) $display("FAIL midrst_ready inst0: data_ready=%b required 1", rdy[0]);
    else pass_cnt++;
    for (int c = 0; c < 30; c++) begin
      tick();
      total_cnt++;
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0)
        $display("FAIL midrst_quiet inst0 clk%0d: done=%b tx=%b busy=%b required 0 1 0",
                 c, done_w[0], tx_w[0], busy_w[0]);
      else pass_cnt++;
    end
    $display("reset mid-frame: aborted");
    send(0, 8'h5A, 1'b0, 1'b0);
    check_frame(0, "after_rst5A");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_data_change();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
